// File: rtl/swg_controller_dyn.sv
// Runtime-configurable sliding-window-generator loop controller.
// Walks an H > W > KH > KW > SIMD nested loop and streams one
// (head increment, tail increment, last) tuple per accepted beat.
// Settings are written into shadow registers and become active only
// at a frame boundary, so a running frame never sees a partial update.
module swg_controller_dyn #(
  parameter int CNT_BITS      = 16,
  parameter int INCR_BITWIDTH = 12,
  parameter int DEF_CNT_H     = 4,
  parameter int DEF_CNT_W     = 4,
  parameter int DEF_CNT_KH    = 3,
  parameter int DEF_CNT_KW    = 3,
  parameter int DEF_CNT_SIMD  = 2,
  parameter int DEF_HEAD_SIMD = 1,
  parameter int DEF_HEAD_KW   = 1,
  parameter int DEF_HEAD_KH   = 10,
  parameter int DEF_HEAD_W    = 1,
  parameter int DEF_HEAD_H    = 1,
  parameter int DEF_TAIL_W    = 1,
  parameter int DEF_TAIL_H    = 1,
  parameter int DEF_TAIL_LAST = 1,
  parameter int DEF_DEPTHWISE = 0,
  localparam int CFG_W = (CNT_BITS > INCR_BITWIDTH) ? CNT_BITS : INCR_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [CFG_W-1:0]         cfg_wdata,
  input  logic                     cfg_commit,
  output logic                     cfg_pending,
  input  logic                     en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INCR_BITWIDTH-1:0] addr_incr,
  output logic [INCR_BITWIDTH-1:0] tail_incr,
  output logic                     out_last,
  output logic                     frame_done
);

  // Level order everywhere below: 0=H, 1=W, 2=KH, 3=KW, 4=SIMD.
  localparam logic [CNT_BITS-1:0] DEF_CNT [5] = '{
    CNT_BITS'(DEF_CNT_H), CNT_BITS'(DEF_CNT_W), CNT_BITS'(DEF_CNT_KH),
    CNT_BITS'(DEF_CNT_KW), CNT_BITS'(DEF_CNT_SIMD)};
  localparam logic [INCR_BITWIDTH-1:0] DEF_HEAD [5] = '{
    INCR_BITWIDTH'(DEF_HEAD_H), INCR_BITWIDTH'(DEF_HEAD_W), INCR_BITWIDTH'(DEF_HEAD_KH),
    INCR_BITWIDTH'(DEF_HEAD_KW), INCR_BITWIDTH'(DEF_HEAD_SIMD)};
  // Tail order: 0=W, 1=H, 2=LAST.
  localparam logic [INCR_BITWIDTH-1:0] DEF_TAIL [3] = '{
    INCR_BITWIDTH'(DEF_TAIL_W), INCR_BITWIDTH'(DEF_TAIL_H), INCR_BITWIDTH'(DEF_TAIL_LAST)};
  localparam logic DEF_DW = (DEF_DEPTHWISE != 0);

  logic [CNT_BITS-1:0]      actCnt_q [5];
  logic [CNT_BITS-1:0]      shCnt_q [5];
  logic [CNT_BITS-1:0]      shCnt_d [5];
  logic [INCR_BITWIDTH-1:0] actHead_q [5];
  logic [INCR_BITWIDTH-1:0] shHead_q [5];
  logic [INCR_BITWIDTH-1:0] shHead_d [5];
  logic [INCR_BITWIDTH-1:0] actTail_q [3];
  logic [INCR_BITWIDTH-1:0] shTail_q [3];
  logic [INCR_BITWIDTH-1:0] shTail_d [3];
  logic                     actDw_q, shDw_q, shDw_d;
  logic                     cfgPending_q;

  logic [CNT_BITS-1:0]      idx_q [5];
  logic                     outValid_q, outLast_q, frameDone_q;
  logic [INCR_BITWIDTH-1:0] addrIncr_q, tailIncr_q, nextAddr_q;

  logic [CNT_BITS-1:0]      actLast [5];
  logic [CNT_BITS-1:0]      useLast [5];
  logic [CNT_BITS-1:0]      nxtIdx [5];
  logic [CNT_BITS-1:0]      loadIdx [5];
  logic [INCR_BITWIDTH-1:0] useTail [3];
  logic [INCR_BITWIDTH-1:0] stepAddr, loadAddr, loadTail;
  logic                     useDw, carry, idxZero, hs, commitReq, applyNow, loadLast;

  // A programmed count of zero behaves like a count of one.
  function automatic logic [CNT_BITS-1:0] lastOf(input logic [CNT_BITS-1:0] c);
    lastOf = (c == '0) ? '0 : c - 1'b1;
  endfunction

  // Shadow register file next-state: host writes land here only.
  always_comb begin
    shCnt_d  = shCnt_q;
    shHead_d = shHead_q;
    shTail_d = shTail_q;
    shDw_d   = shDw_q;
    if (cfg_we) begin
      case (cfg_addr)
        4'd0:    shCnt_d[0]  = cfg_wdata[CNT_BITS-1:0];
        4'd1:    shCnt_d[1]  = cfg_wdata[CNT_BITS-1:0];
        4'd2:    shCnt_d[2]  = cfg_wdata[CNT_BITS-1:0];
        4'd3:    shCnt_d[3]  = cfg_wdata[CNT_BITS-1:0];
        4'd4:    shCnt_d[4]  = cfg_wdata[CNT_BITS-1:0];
        4'd5:    shHead_d[4] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd6:    shHead_d[3] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd7:    shHead_d[2] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd8:    shHead_d[1] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd9:    shHead_d[0] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd10:   shTail_d[0] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd11:   shTail_d[1] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd12:   shTail_d[2] = cfg_wdata[INCR_BITWIDTH-1:0];
        4'd13:   shDw_d      = cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Loop stepping, commit decision and the tuple to present next.
  always_comb begin
    for (int i = 0; i < 5; i++) actLast[i] = lastOf(actCnt_q[i]);

    // Odometer step from the innermost level; the first level that does not
    // wrap is the outermost one that changed and supplies the head increment.
    carry    = 1'b1;
    stepAddr = '0;
    for (int i = 4; i >= 0; i--) begin
      nxtIdx[i] = idx_q[i];
      if (carry) begin
        if (idx_q[i] == actLast[i]) begin
          nxtIdx[i] = '0;
        end else begin
          nxtIdx[i] = idx_q[i] + 1'b1;
          stepAddr  = actHead_q[i];
          carry     = 1'b0;
        end
      end
    end

    idxZero = 1'b1;
    for (int i = 0; i < 5; i++) if (idx_q[i] != '0) idxZero = 1'b0;

    hs        = outValid_q && out_ready;
    commitReq = cfgPending_q || cfg_commit;
    applyNow  = commitReq && ((hs && outLast_q) || (!outValid_q && idxZero));

    // A tuple loaded at a commit boundary is the first beat of the new frame.
    for (int i = 0; i < 5; i++) useLast[i] = lastOf(applyNow ? shCnt_d[i] : actCnt_q[i]);
    for (int i = 0; i < 3; i++) useTail[i] = applyNow ? shTail_d[i] : actTail_q[i];
    useDw = applyNow ? shDw_d : actDw_q;

    for (int i = 0; i < 5; i++) loadIdx[i] = outValid_q ? nxtIdx[i] : idx_q[i];
    loadAddr = outValid_q ? stepAddr : nextAddr_q;

    loadLast = 1'b1;
    for (int i = 0; i < 5; i++) if (loadIdx[i] != useLast[i]) loadLast = 1'b0;

    if (useDw && (loadIdx[2] < useLast[2]))  loadTail = INCR_BITWIDTH'(1);
    else if (loadIdx[1] < useLast[1])        loadTail = useTail[0];
    else if (loadIdx[0] < useLast[0])        loadTail = useTail[1];
    else                                     loadTail = useTail[2];
  end

  // Shadow/active configuration registers and the pending-commit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      actCnt_q     <= DEF_CNT;
      shCnt_q      <= DEF_CNT;
      actHead_q    <= DEF_HEAD;
      shHead_q     <= DEF_HEAD;
      actTail_q    <= DEF_TAIL;
      shTail_q     <= DEF_TAIL;
      actDw_q      <= DEF_DW;
      shDw_q       <= DEF_DW;
      cfgPending_q <= 1'b0;
    end else begin
      shCnt_q      <= shCnt_d;
      shHead_q     <= shHead_d;
      shTail_q     <= shTail_d;
      shDw_q       <= shDw_d;
      cfgPending_q <= commitReq && !applyNow;
      if (applyNow) begin
        actCnt_q  <= shCnt_d;
        actHead_q <= shHead_d;
        actTail_q <= shTail_d;
        actDw_q   <= shDw_d;
      end
    end
  end

  // Loop indices and the registered output tuple with its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '{default: '0};
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      frameDone_q <= 1'b0;
      addrIncr_q  <= '0;
      tailIncr_q  <= '0;
      nextAddr_q  <= '0;
    end else begin
      frameDone_q <= hs && outLast_q;
      if (hs) idx_q <= nxtIdx;
      if ((hs || !outValid_q) && en) begin
        outValid_q <= 1'b1;
        addrIncr_q <= loadAddr;
        tailIncr_q <= loadTail;
        outLast_q  <= loadLast;
      end else if (hs) begin
        outValid_q <= 1'b0;
        nextAddr_q <= stepAddr;
      end
    end
  end

  assign cfg_pending = cfgPending_q;
  assign out_valid   = outValid_q;
  assign addr_incr   = addrIncr_q;
  assign tail_incr   = tailIncr_q;
  assign out_last    = outLast_q;
  assign frame_done  = frameDone_q;

endmodule

// File: doc/swg_controller_dyn.md
Name: swg_controller_dyn

Overview:
- Runtime-configurable successor to the sliding-window-generator loop controller.
- Walks a five-level nested loop (H > W > KH > KW > SIMD) and emits one address-increment tuple per beat over a ready/valid stream.
- Loop counts, head increments, tail increments and the depthwise mode are programmed through a register port. New settings are committed atomically at frame boundaries.
- Sits between the host config interface and the addressable cyclic-buffer read/write address logic of the dynamic SWG.

Parameters:
- CNT_BITS, 16, width of each loop count register.
- INCR_BITWIDTH, 12, width of addr_incr/tail_incr and of the increment registers (two's complement).
- DEF_CNT_H / DEF_CNT_W / DEF_CNT_KH / DEF_CNT_KW / DEF_CNT_SIMD, 4/4/3/3/2, reset iteration counts.
- DEF_HEAD_SIMD/KW/KH/W/H, 1/1/10/1/1, reset head increments.
- DEF_TAIL_W/H/LAST, 1/1/1, reset tail increments.
- DEF_DEPTHWISE, 0, reset depthwise flag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  shadow-register write strobe
- cfg_addr  in  4  register index: 0-4 counts H,W,KH,KW,SIMD; 5-9 head SIMD,KW,KH,W,H; 10-12 tail W,H,LAST; 13 depthwise (bit 0)
- cfg_wdata  in  max(CNT_BITS,INCR_BITWIDTH)  write data, LSB-aligned
- cfg_commit  in  1  request that shadow registers become active at the next frame start
- cfg_pending  out  1  commit requested but not yet applied
- en  in  1  allow generation
- out_valid  out  1  tuple valid
- out_ready  in  1  consumer accepts tuple
- addr_incr  out  INCR_BITWIDTH  head address increment for this beat
- tail_incr  out  INCR_BITWIDTH  tail increment for this beat
- out_last  out  1  last beat of frame
- frame_done  out  1  one-cycle pulse after last-beat handshake

Behaviour:
- Reset (async assert, sync release):
  - Active and shadow registers take the DEF_* values.
  - All loop indices are 0.
  - out_valid=0, cfg_pending=0, frame_done=0, addr_incr=0, tail_incr=0, out_last=0.
- Counts:
  - A count value of 0 is treated as 1.
  - Each level index runs 0..CNT-1.
  - Beats per frame = product of the five counts.
- Generation:
  - out_valid rises the first cycle after reset release in which en=1.
  - Outputs are registered and held stable while out_valid && !out_ready.
  - On a handshake: if en=1 the next tuple is presented the following cycle (1 beat/cycle throughput); if en=0, out_valid drops after the handshake.
  - en deasserting without a handshake does not drop an already-valid tuple.
- addr_incr:
  - 0 for the first beat of every frame.
  - Otherwise the HEAD increment of the outermost level whose index changed since the previous beat. Inner levels that wrapped to 0 do not contribute.
- tail_incr is evaluated on the current beat's indices:
  - 1 if depthwise and kh < CNT_KH-1;
  - else TAIL_W if w < CNT_W-1;
  - else TAIL_H if h < CNT_H-1;
  - else TAIL_LAST.
- out_last=1 when all indices equal CNT-1.
- Frame end: the handshake of the out_last beat wraps all indices to 0 and pulses frame_done in the next cycle.
- Config writes:
  - cfg_we updates only shadow registers; values are truncated to register width.
  - Writes to addresses 14-15 are ignored.
- Commit:
  - cfg_commit sets cfg_pending.
  - Shadow values are copied to the active registers when the last-beat handshake occurs, or immediately if out_valid=0 and all indices are 0 (idle at frame start).
  - cfg_pending clears in the same cycle as the copy.
  - A cfg_we in the same cycle as cfg_commit is included in the commit.
  - A commit arriving in the same cycle as the last-beat handshake applies at that boundary.
  - Repeated commits while pending are absorbed into one.
- Mid-frame writes/commits never alter the running frame.
- Reset mid-frame aborts immediately: indices go to 0, active config returns to DEF_*, no frame_done is emitted.
- Arithmetic: increments are sign-extended from register width. No saturation; outputs are INCR_BITWIDTH two's complement.

Test Plan:
- Defaults, out_ready=1, en=1 → 4*4*3*3*2=288 beats. Beat0 addr_incr=0; beats 1,2 = SIMD/KW pattern (1,1); first KH step =10. out_last only on beat 287; frame_done pulse one cycle after it; next frame restarts with addr_incr=0.
- Program counts 1,1,2,2,1 and heads KW=3, KH=7, commit while idle → 4-beat frame with addr_incr 0,3,7,3; cfg_pending clears the same cycle.
- Commit at beat 100 of a default frame → remaining 188 beats still use defaults; new config applies from the next frame; cfg_pending high until the beat-287 handshake.
- Random out_ready backpressure (50%) → tuple stable while stalled; total beat count and sequence identical to the no-stall run.
- Depthwise=1, CNT_KH=3 → tail_incr=1 while kh<2; TAIL_W (set to 5) otherwise; TAIL_LAST (set to -4, 0xFFC) on the final beat.
- Assert rst mid-frame (asynchronously, between clock edges) → out_valid=0 immediately; after release the sequence restarts from beat0 with DEF_* config and no frame_done is emitted.
